func_sweep_ctrl: RTL and testbench
==================================

Name: func_sweep_ctrl

Overview:
Sequencer for the 4-input transistor-level function unit F = AC + ABC' + BD + A'C'D'.
- On a start pulse it drives all 16 input combinations onto A,B,C,D in order 0..15, with A as MSB.
- After each drive it waits a programmable settle time, then samples F.
- It builds a 16-bit captured truth table and compares each sample against a golden table.
- It reports an error count, the first failing index, and pass/fail.
- It sits beside the function unit as its self-test and characterisation controller.

Parameters:
SETTLE, 2, wait cycles between driving a vector and sampling F (0..15 legal)
GOLDEN, 16'hFCB1, expected F per index; bit i = F for {A,B,C,D}=i

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin sweep; sampled only in IDLE
abort  input  1  cancel sweep; sampled in any busy state
F  input  1  output of function unit under control
A  output  1  input bit 3 to function unit (MSB of index)
B  output  1  input bit 2
C  output  1  input bit 1
D  output  1  input bit 0
busy  output  1  sweep in progress
done  output  1  one-cycle pulse on normal completion
pass  output  1  held high after a completed sweep with zero errors
captured  output  16  sampled F per index
err_count  output  5  mismatches in current/last sweep (0..16)
first_err  output  4  index of first mismatch
first_err_valid  output  1  first_err holds a valid index

Behaviour:
- Reset (rst=1 at edge): state IDLE.
  - Outputs A..D=0, busy=0, done=0, pass=0, captured=0, err_count=0, first_err=0, first_err_valid=0.
  - Reset overrides everything, including mid-sweep.
- A,B,C,D are driven from a registered 4-bit index idx, with A=idx[3] and D=idx[0]. idx=0 whenever the block is in IDLE.
- IDLE, start=1 and abort=0 -> DRIVE.
  - idx<=0, busy<=1, pass<=0.
  - captured, err_count, first_err and first_err_valid are cleared.
  - start=1 together with abort=1 in IDLE: remain IDLE, no effect.
- DRIVE (1 cycle): idx is stable on A..D.
  - SETTLE=0 -> SAMPLE.
  - SETTLE>0 -> WAIT, with cnt<=SETTLE.
- WAIT: cnt decrements each cycle. When cnt==1, go to SAMPLE. Total time in WAIT is exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - captured[idx]<=F.
  - If F!=GOLDEN[idx]: err_count++. If first_err_valid=0 as well: first_err<=idx and first_err_valid<=1.
  - If idx==15 -> DONE; else idx<=idx+1 and go to DRIVE. idx never wraps inside a sweep.
- DONE (1 cycle): done=1, busy<=0, pass<=(err_count==0 including the final sample). Next state IDLE, idx<=0.
- Latency: each vector takes SETTLE+2 cycles, so a sweep takes 16*(SETTLE+2) cycles.
  - done is high in cycle 16*(SETTLE+2)+1 after the start edge.
  - With SETTLE=2, done is high 65 cycles after start is accepted.
- start while busy is ignored; no restart and no queueing.
- abort=1 in DRIVE, WAIT or SAMPLE -> IDLE at the next edge.
  - busy=0; done is not pulsed; pass stays 0.
  - captured, err_count and first_err keep their partial values.
  - A SAMPLE cycle coinciding with abort does not update captured or err_count.
  - abort in IDLE or DONE has no effect; DONE always completes.
- err_count saturation is not needed: the maximum is 16, which fits in 5 bits.
- All outputs are registered except done, which is a decode of state DONE. There are no combinational paths from F to any output.

Test Plan:
1. Reset, SETTLE=2, F from a correct model of the function, start pulse -> done pulses 65 cycles later; captured=16'hFCB1, err_count=0, first_err_valid=0, pass=1, busy low after done.
2. F tied 0 -> captured=16'h0000, err_count=10, first_err=0, first_err_valid=1, pass=0.
3. F = inverted model -> captured=16'h034E, err_count=16, first_err=0, pass=0.
4. Correct model with F forced to 1 only at index 9 -> captured=16'hFEB1, err_count=1, first_err=9, pass=0.
5. Start, abort on cycle 20 -> busy=0 next edge, done never pulses, pass=0, A..D=0. Start pulses while busy (before the abort) change nothing. start+abort together in IDLE -> stays IDLE.
6. SETTLE=0: sweep takes 32 cycles, results as in test 1. Separate run with rst asserted at cycle 30 mid-sweep -> all outputs return to their reset values at the next edge, and a new start then completes normally.

Source files
------------

// File: rtl/func_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// func_sweep_ctrl
//
// Self-test and characterisation sequencer for the 4-input function unit
// F = AC + ABC' + BD + A'C'D'. A start pulse walks {A,B,C,D} through indices
// 0..15 (A is the MSB). Each index is held for SETTLE cycles before F is
// sampled. Samples build a captured truth table and are compared against
// GOLDEN to produce an error count, the first failing index and a pass flag.
//
// Per-vector timing: DRIVE (1) + WAIT (SETTLE) + SAMPLE (1) = SETTLE+2
// cycles. A sweep therefore lasts 16*(SETTLE+2) cycles, followed by a single
// DONE cycle.
//
// Parameters
//   SETTLE          settle cycles between driving a vector and sampling (0..15)
//   GOLDEN          expected F per index, bit i = F for {A,B,C,D} = i
//
// Ports
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   start           begin a sweep; honoured only in IDLE, and not with abort
//   abort           cancel a sweep in DRIVE/WAIT/SAMPLE; partial results kept
//   F               output of the function unit under control
//   A, B, C, D      function unit inputs, A = idx[3] ... D = idx[0]
//   busy            sweep in progress
//   done            one-cycle pulse on normal completion (decode of DONE)
//   pass            high after a completed sweep with zero mismatches
//   captured        sampled F per index
//   err_count       mismatches in the current or last sweep (0..16)
//   first_err       index of the first mismatch
//   first_err_valid first_err holds a valid index
// -----------------------------------------------------------------------------
module func_sweep_ctrl #(
  parameter int unsigned SETTLE = 2,
  parameter logic [15:0] GOLDEN = 16'hFCB1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        F,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] captured,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        first_err_valid
);

  localparam logic [3:0] SETTLE_CYC = 4'(SETTLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        pass_q, pass_d;
  logic [15:0] captured_q, captured_d;
  logic [4:0]  err_count_q, err_count_d;
  logic [3:0]  first_err_q, first_err_d;
  logic        first_err_valid_q, first_err_valid_d;
  logic        abort_busy;

  // Abort only acts in the sweep states; IDLE ignores it and DONE always
  // completes so a finished sweep can never be lost.
  assign abort_busy = abort &&
                      ((state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_SAMPLE));

  always_comb begin
    // NOTE: every next-state signal gets a hold default first, so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d           = state_q;
    idx_d             = idx_q;
    cnt_d             = cnt_q;
    busy_d            = busy_q;
    pass_d            = pass_q;
    captured_d        = captured_q;
    err_count_d       = err_count_q;
    first_err_d       = first_err_q;
    first_err_valid_d = first_err_valid_q;

    if (abort_busy) begin
      // Partial results stay visible; an aborting SAMPLE records nothing.
      state_d = S_IDLE;
      idx_d   = '0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d           = S_DRIVE;
            idx_d             = '0;
            busy_d            = 1'b1;
            pass_d            = 1'b0;
            captured_d        = '0;
            err_count_d       = '0;
            first_err_d       = '0;
            first_err_valid_d = 1'b0;
          end
        end

        S_DRIVE: begin
          if (SETTLE_CYC == 4'd0) begin
            state_d = S_SAMPLE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = SETTLE_CYC;
          end
        end

        // cnt counts SETTLE..1, so WAIT lasts exactly SETTLE cycles.
        S_WAIT: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = S_SAMPLE;
          end
        end

        S_SAMPLE: begin
          captured_d[idx_q] = F;
          if (F != GOLDEN[idx_q]) begin
            err_count_d = err_count_q + 5'd1;
            if (!first_err_valid_q) begin
              first_err_d       = idx_q;
              first_err_valid_d = 1'b1;
            end
          end
          if (idx_q == 4'd15) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_DRIVE;
          end
        end

        // err_count_q already includes the final sample here.
        S_DONE: begin
          state_d = S_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
          pass_d  = (err_count_q == 5'd0);
        end

        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      idx_q             <= '0;
      cnt_q             <= '0;
      busy_q            <= 1'b0;
      pass_q            <= 1'b0;
      captured_q        <= '0;
      err_count_q       <= '0;
      first_err_q       <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      cnt_q             <= cnt_d;
      busy_q            <= busy_d;
      pass_q            <= pass_d;
      captured_q        <= captured_d;
      err_count_q       <= err_count_d;
      first_err_q       <= first_err_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  assign A               = idx_q[3];
  assign B               = idx_q[2];
  assign C               = idx_q[1];
  assign D               = idx_q[0];
  assign busy            = busy_q;
  assign done            = (state_q == S_DONE);
  assign pass            = pass_q;
  assign captured        = captured_q;
  assign err_count       = err_count_q;
  assign first_err       = first_err_q;
  assign first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_func_sweep_ctrl
//
// Two controllers run side by side: instance 0 with SETTLE=2 and instance 1
// with SETTLE=0. The function unit is modelled as the boolean equation with a
// per-instance fault mask XORed onto its output, so any truth table can be
// presented. Each started sweep pushes its expected result onto a queue; a
// monitor pops and compares whenever done pulses, then checks the settled
// outputs one cycle later. Aborts and resets are checked inline.
// -----------------------------------------------------------------------------
module tb_func_sweep_ctrl;

  typedef struct {
    logic [15:0] cap;
    logic [4:0]  ec;
    logic [3:0]  fe;
    logic        fev;
    logic        pass;
    int          t0;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  int          cyc = 0;

  logic        rst      [2];
  logic        start    [2];
  logic        abort    [2];
  logic        f        [2];
  logic        a        [2];
  logic        b        [2];
  logic        c        [2];
  logic        d        [2];
  logic        busy     [2];
  logic        done     [2];
  logic        pass     [2];
  logic        fev      [2];
  logic [15:0] cap      [2];
  logic [4:0]  ec       [2];
  logic [3:0]  fe       [2];
  logic [15:0] mask     [2];

  int          n_vec = 0;
  int          n_err = 0;

  exp_t        sb0[$];
  exp_t        sb1[$];
  exp_t        pend_e   [2];
  bit          pend     [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  func_sweep_ctrl #(.SETTLE(2)) u_dut_s2 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .abort(abort[0]), .F(f[0]),
    .A(a[0]), .B(b[0]), .C(c[0]), .D(d[0]), .busy(busy[0]), .done(done[0]),
    .pass(pass[0]), .captured(cap[0]), .err_count(ec[0]), .first_err(fe[0]),
    .first_err_valid(fev[0])
  );

  func_sweep_ctrl #(.SETTLE(0)) u_dut_s0 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .abort(abort[1]), .F(f[1]),
    .A(a[1]), .B(b[1]), .C(c[1]), .D(d[1]), .busy(busy[1]), .done(done[1]),
    .pass(pass[1]), .captured(cap[1]), .err_count(ec[1]), .first_err(fe[1]),
    .first_err_valid(fev[1])
  );

  // The intended function, straight from its sum-of-products form.
  function automatic logic feq(input logic [3:0] i);
    logic va, vb, vc, vd;
    va = i[3]; vb = i[2]; vc = i[1]; vd = i[0];
    return (va & vc) | (va & vb & ~vc) | (vb & vd) | (~va & ~vc & ~vd);
  endfunction

  // Function unit seen by each controller: true function, faulted by mask.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      f[k] = feq({a[k], b[k], c[k], d[k]}) ^ mask[k][{a[k], b[k], c[k], d[k]}];
    end
  end

  // Expected results after the first n samples of a sweep with fault mask m.
  function automatic exp_t model(input logic [15:0] m, input int n,
                                 input int t0, input int lat);
    exp_t e;
    logic fv;
    e.cap = '0; e.ec = '0; e.fe = '0; e.fev = 1'b0;
    for (int i = 0; i < n; i++) begin
      fv = feq(4'(i)) ^ m[i];
      e.cap[i] = fv;
      if (fv != feq(4'(i))) begin
        e.ec = e.ec + 5'd1;
        if (!e.fev) begin
          e.fe  = 4'(i);
          e.fev = 1'b1;
        end
      end
    end
    e.pass = (n == 16) && (e.ec == 5'd0);
    e.t0   = t0;
    e.lat  = lat;
    return e;
  endfunction

  task automatic check(input int k, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[dut%0d]: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  task automatic check_results(input int k, input string tag, input exp_t e);
    check(k, {tag, "_captured"},  32'(cap[k]), 32'(e.cap));
    check(k, {tag, "_err_count"}, 32'(ec[k]),  32'(e.ec));
    check(k, {tag, "_first_err"}, 32'(fe[k]),  32'(e.fe));
    check(k, {tag, "_first_ev"},  32'(fev[k]), 32'(e.fev));
    check(k, {tag, "_pass"},      32'(pass[k]), 32'(e.pass));
    check(k, {tag, "_busy"},      32'(busy[k]), 32'd0);
    check(k, {tag, "_abcd"},      32'({a[k], b[k], c[k], d[k]}), 32'd0);
  endtask

  task automatic check_reset(input int k, input string tag);
    exp_t z;
    z = model(16'h0000, 0, 0, 0);
    check_results(k, tag, z);
    check(k, {tag, "_done"}, 32'(done[k]), 32'd0);
  endtask

  // Monitor: pops the scoreboard on each done pulse, checks the latency at the
  // pulse and the settled outputs one cycle after it.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pend[k]) begin
        pend[k] = 1'b0;
        check_results(k, "sweep", pend_e[k]);
        check(k, "done_width", 32'(done[k]), 32'd0);
      end
      if (done[k]) begin
        exp_t e;
        bit   have;
        have = 1'b0;
        if (k == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
        if (k == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
        if (!have) begin
          check(k, "unexpected_done", 32'd1, 32'd0);
        end else begin
          check(k, "done_latency", 32'(cyc - e.t0), 32'(e.lat));
          pend_e[k] = e;
          pend[k]   = 1'b1;
        end
      end
    end
  end

  function automatic int period(input int k);
    return (k == 0) ? 4 : 2;
  endfunction

  function automatic logic [15:0] rand_mask();
    unique case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'(1) << $urandom_range(0, 15);
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic wait_idle(input int k);
    int w;
    w = 0;
    while (busy[k] && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2000) check(k, "busy_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Full sweep; optionally a stray start pulse mid-sweep that must be ignored.
  task automatic run_sweep(input int k, input logic [15:0] m, input bit stray);
    exp_t e;
    mask[k] = m;
    @(negedge clk);
    start[k] = 1'b1;
    e = model(m, 16, cyc, 16 * period(k) + 1);
    if (k == 0) sb0.push_back(e); else sb1.push_back(e);
    @(negedge clk);
    start[k] = 1'b0;
    if (stray) begin
      repeat ($urandom_range(2, 20)) @(negedge clk);
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
    end
    wait_idle(k);
  endtask

  // Sweep aborted while in sweep cycle j (j >= 4); optionally follow with a
  // start+abort pair in IDLE that must be ignored.
  task automatic run_abort(input int k, input logic [15:0] m, input int j,
                           input bit idle_pair);
    exp_t e;
    int   t0;
    bit   seen;
    mask[k] = m;
    @(negedge clk);
    start[k] = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start[k] = 1'b0;
    start[k] = 1'b1;                 // stray start while busy
    @(negedge clk);
    start[k] = 1'b0;
    while (cyc < t0 + j) @(negedge clk);
    abort[k] = 1'b1;
    @(negedge clk);
    abort[k] = 1'b0;
    e = model(m, (j - 1) / period(k), 0, 0);
    check_results(k, "abort", e);
    check(k, "abort_done", 32'(done[k]), 32'd0);
    seen = 1'b0;
    repeat (16 * period(k) + 4) begin
      @(negedge clk);
      if (done[k] || busy[k]) seen = 1'b1;
    end
    check(k, "abort_quiet", 32'(seen), 32'd0);
    if (idle_pair) begin
      start[k] = 1'b1;
      abort[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
      abort[k] = 1'b0;
      repeat (3) @(negedge clk);
      check_results(k, "idle_pair", e);
    end
  endtask

  // Reset asserted j cycles into a sweep must restore all reset values.
  task automatic run_reset_mid(input int k, input logic [15:0] m, input int j);
    int t0;
    mask[k] = m;
    @(negedge clk);
    start[k] = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start[k] = 1'b0;
    while (cyc < t0 + j) @(negedge clk);
    rst[k] = 1'b1;
    @(negedge clk);
    check_reset(k, "mid_reset");
    rst[k] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [15:0] tie0;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; abort[k] = 1'b0; mask[k] = '0; pend[k] = 1'b0;
    end
    // Mask that cancels the true function everywhere: F stuck at 0.
    for (int i = 0; i < 16; i++) tie0[i] = feq(4'(i));

    repeat (3) @(negedge clk);
    check_reset(0, "reset");
    check_reset(1, "reset");
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (2) @(negedge clk);

    // SETTLE=2 directed cases.
    run_sweep(0, 16'h0000, 1'b0);    // correct unit
    run_sweep(0, tie0,     1'b1);    // F tied 0
    run_sweep(0, 16'hFFFF, 1'b0);    // inverted unit
    run_sweep(0, 16'h0200, 1'b1);    // index 9 forced to 1
    run_abort(0, 16'h0000, 20, 1'b1);
    // SETTLE=2 random cases.
    repeat (6) run_sweep(0, rand_mask(), 1'($urandom_range(0, 1)));
    repeat (3) run_abort(0, rand_mask(), $urandom_range(4, 64), 1'b0);

    // SETTLE=0 cases.
    run_sweep(1, 16'h0000, 1'b0);
    run_reset_mid(1, 16'h0000, 30);
    run_sweep(1, 16'h0000, 1'b0);
    repeat (6) run_sweep(1, rand_mask(), 1'($urandom_range(0, 1)));
    repeat (3) run_abort(1, rand_mask(), $urandom_range(4, 32), 1'($urandom_range(0, 1)));

    repeat (4) @(negedge clk);
    check(0, "sb_leftover", 32'(sb0.size()), 32'd0);
    check(1, "sb_leftover", 32'(sb1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
